// File: rtl/dp_ctrl_pkg.sv
// Shared encodings for the CNN datapath control sequencer: layer ops,
// sequencer states and the op normalisation helper.
package dp_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_CONV = 2'b00,
    OP_POOL = 2'b01,
    OP_RELU = 2'b10
  } op_e;

  // The output mux select uses the same codes as the layer op.
  localparam logic [1:0] MUX_CONV = OP_CONV;
  localparam logic [1:0] MUX_POOL = OP_POOL;
  localparam logic [1:0] MUX_RELU = OP_RELU;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_W   = 3'd1,
    W_SETTLE = 3'd2,
    RUN      = 3'd3,
    DRAIN    = 3'd4,
    DONE     = 3'd5
  } state_e;

  // The reserved code 11 behaves exactly like relu.
  function automatic op_e to_op(input logic [1:0] code);
    case (code)
      2'b00:   return OP_CONV;
      2'b01:   return OP_POOL;
      default: return OP_RELU;
    endcase
  endfunction

endpackage

// File: rtl/addr_seq_counter.sv
// Base-plus-offset address generator with a terminal-count flag; the
// address wraps at ADDR_WIDTH while the offset counts one bit wider.
module addr_seq_counter #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   limit,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH:0]   offset,
  output logic                  last
);

  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   limit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      limit_q <= '0;
      offset  <= '0;
    end else if (load) begin
      base_q  <= base;
      limit_q <= limit;
      offset  <= '0;
    end else if (enable) begin
      offset <= offset + 1'b1;
    end
  end

  // A zero limit never matches, so an unloaded counter never reports last.
  assign addr = base_q + offset[ADDR_WIDTH-1:0];
  assign last = (limit_q != '0) && (offset == limit_q - 1'b1);

endmodule

// File: rtl/dp_layer_sequencer.sv
// Start/busy/done engine driving the CNN datapath controls: conv layers
// preload the weight window then stream the feature map; pool/relu only stream.
module dp_layer_sequencer
  import dp_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH      = 11,
  parameter int N               = 5,
  parameter int W_SETTLE_CYCLES = 2,
  parameter int DRAIN_CYCLES    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               cfg_op,
  input  logic [2:0]               cfg_mode,
  input  logic [ADDR_WIDTH-1:0]    cfg_w_base,
  input  logic [ADDR_WIDTH-1:0]    cfg_src_base,
  input  logic [ADDR_WIDTH:0]      cfg_src_len,
  output logic                     busy,
  output logic                     done,
  output logic                     ctrl_ram_en,
  output logic                     ctrl_WorI,
  output logic [2:0]               ctrl_mode,
  output logic [1:0]               ctrl_mux_sel,
  output logic [ADDR_WIDTH-1:0]    ctrl_read_addr,
  output logic [$clog2(N*N)-1:0]   ctrl_weight_location,
  output logic                     ctrl_addr_ctrl_en
);

  localparam int WLOC_W   = $clog2(N*N);
  localparam int LEN_W    = ADDR_WIDTH + 1;
  localparam int WAIT_MAX = (W_SETTLE_CYCLES > DRAIN_CYCLES) ? W_SETTLE_CYCLES : DRAIN_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  state_e                state_q, state_d;
  op_e                   op_q;
  logic [2:0]            mode_q;
  logic [ADDR_WIDTH-1:0] src_base_q;
  logic [LEN_W-1:0]      len_q;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  capture;

  logic                  busy_d, done_d, ram_en_d, wori_d, ace_d;
  logic [2:0]            mode_d;
  logic [1:0]            mux_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [WLOC_W-1:0]     loc_d;

  logic                  cnt_load, cnt_en, cnt_last;
  logic [ADDR_WIDTH-1:0] cnt_base, cnt_addr;
  logic [LEN_W-1:0]      cnt_limit, cnt_offset;

  addr_seq_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cnt_load),
    .enable (cnt_en),
    .base   (cnt_base),
    .limit  (cnt_limit),
    .addr   (cnt_addr),
    .offset (cnt_offset),
    .last   (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    capture   = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_base  = src_base_q;
    cnt_limit = len_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    ram_en_d  = 1'b0;
    wori_d    = 1'b0;
    mode_d    = '0;
    mux_d     = '0;
    addr_d    = '0;
    loc_d     = '0;
    ace_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          capture = 1'b1;
          wait_d  = '0;
          if (cfg_src_len == '0) begin
            state_d = DONE;
          end else if (to_op(cfg_op) == OP_CONV) begin
            state_d   = LOAD_W;
            cnt_load  = 1'b1;
            cnt_base  = cfg_w_base;
            cnt_limit = LEN_W'(N*N);
          end else begin
            state_d   = RUN;
            cnt_load  = 1'b1;
            cnt_base  = cfg_src_base;
            cnt_limit = cfg_src_len;
          end
        end
      end
      LOAD_W: begin
        busy_d   = 1'b1;
        ram_en_d = 1'b1;
        wori_d   = 1'b1;
        addr_d   = cnt_addr;
        loc_d    = WLOC_W'(cnt_offset);
        // The stream phase reuses the counter, so reload it on the last weight.
        if (cnt_last) begin
          state_d  = W_SETTLE;
          cnt_load = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      W_SETTLE: begin
        busy_d = 1'b1;
        wori_d = 1'b1;
        loc_d  = WLOC_W'(N*N - 1);
        addr_d = ctrl_read_addr;
        wait_d = wait_q + 1'b1;
        if (wait_q == WAIT_W'(W_SETTLE_CYCLES - 1)) begin
          state_d = RUN;
          wait_d  = '0;
        end
      end
      RUN: begin
        busy_d   = 1'b1;
        ram_en_d = 1'b1;
        addr_d   = cnt_addr;
        mode_d   = mode_q;
        mux_d    = op_q;
        ace_d    = (op_q == OP_CONV);
        if (cnt_last) state_d = DRAIN;
        else          cnt_en  = 1'b1;
      end
      DRAIN: begin
        busy_d = 1'b1;
        addr_d = ctrl_read_addr;
        mode_d = mode_q;
        mux_d  = op_q;
        ace_d  = (op_q == OP_CONV);
        wait_d = wait_q + 1'b1;
        if (wait_q == WAIT_W'(DRAIN_CYCLES - 1)) begin
          state_d = DONE;
          wait_d  = '0;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything and suppresses any pending done pulse.
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      wait_d   = '0;
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      ram_en_d = 1'b0;
      wori_d   = 1'b0;
      mode_d   = '0;
      mux_d    = '0;
      addr_d   = '0;
      loc_d    = '0;
      ace_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_CONV;
      mode_q     <= '0;
      src_base_q <= '0;
      len_q      <= '0;
    end else if (capture) begin
      op_q       <= to_op(cfg_op);
      mode_q     <= cfg_mode;
      src_base_q <= cfg_src_base;
      len_q      <= cfg_src_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy                 <= 1'b0;
      done                 <= 1'b0;
      ctrl_ram_en          <= 1'b0;
      ctrl_WorI            <= 1'b0;
      ctrl_mode            <= '0;
      ctrl_mux_sel         <= '0;
      ctrl_read_addr       <= '0;
      ctrl_weight_location <= '0;
      ctrl_addr_ctrl_en    <= 1'b0;
    end else begin
      busy                 <= busy_d;
      done                 <= done_d;
      ctrl_ram_en          <= ram_en_d;
      ctrl_WorI            <= wori_d;
      ctrl_mode            <= mode_d;
      ctrl_mux_sel         <= mux_d;
      ctrl_read_addr       <= addr_d;
      ctrl_weight_location <= loc_d;
      ctrl_addr_ctrl_en    <= ace_d;
    end
  end

endmodule

// File: tb/tb_dp_layer_sequencer.sv
// Self-checking bench for dp_layer_sequencer: each job's expected per-cycle
// output trace is built from the layer rules and compared cycle by cycle.
module tb_dp_layer_sequencer;

  localparam int AW     = 11;
  localparam int NN     = 25;
  localparam int SETTLE = 2;
  localparam int DRAIN  = 4;
  localparam int SPAN   = 2048;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       ram_en;
    logic       wori;
    logic [2:0] mode;
    logic [1:0] mux;
    logic [10:0] addr;
    logic [4:0] loc;
    logic       ace;
  } out_t;

  localparam int OUT_W = $bits(out_t);

  logic          clk = 1'b0;
  logic          rst_n, start, abort;
  logic [1:0]    cfg_op;
  logic [2:0]    cfg_mode;
  logic [AW-1:0] cfg_w_base, cfg_src_base;
  logic [AW:0]   cfg_src_len;
  logic          busy, done, ctrl_ram_en, ctrl_WorI, ctrl_addr_ctrl_en;
  logic [2:0]    ctrl_mode;
  logic [1:0]    ctrl_mux_sel;
  logic [AW-1:0] ctrl_read_addr;
  logic [4:0]    ctrl_weight_location;

  int   check_cnt = 0;
  int   pass_cnt  = 0;
  out_t exp_q[$];
  out_t msk_q[$];

  dp_layer_sequencer dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .abort                (abort),
    .cfg_op               (cfg_op),
    .cfg_mode             (cfg_mode),
    .cfg_w_base           (cfg_w_base),
    .cfg_src_base         (cfg_src_base),
    .cfg_src_len          (cfg_src_len),
    .busy                 (busy),
    .done                 (done),
    .ctrl_ram_en          (ctrl_ram_en),
    .ctrl_WorI            (ctrl_WorI),
    .ctrl_mode            (ctrl_mode),
    .ctrl_mux_sel         (ctrl_mux_sel),
    .ctrl_read_addr       (ctrl_read_addr),
    .ctrl_weight_location (ctrl_weight_location),
    .ctrl_addr_ctrl_en    (ctrl_addr_ctrl_en)
  );

  always #5 clk = ~clk;

  function automatic out_t sample();
    out_t s;
    s.busy   = busy;
    s.done   = done;
    s.ram_en = ctrl_ram_en;
    s.wori   = ctrl_WorI;
    s.mode   = ctrl_mode;
    s.mux    = ctrl_mux_sel;
    s.addr   = ctrl_read_addr;
    s.loc    = ctrl_weight_location;
    s.ace    = ctrl_addr_ctrl_en;
    return s;
  endfunction

  // Expected trace: cycle k of the job is entry k-1 of exp_q.
  task automatic build_model(input logic [1:0] op, input logic [2:0] mode,
                             input int w_base, input int src_base, input int len);
    out_t e, full, m;
    full = '1;
    exp_q.delete();
    msk_q.delete();
    if (len > 0) begin
      if (op == 2'b00) begin
        for (int k = 0; k < NN; k++) begin
          e = '0; e.busy = 1; e.ram_en = 1; e.wori = 1;
          e.addr = 11'((w_base + k) % SPAN);
          e.loc  = 5'(k);
          exp_q.push_back(e); msk_q.push_back(full);
        end
        for (int s = 0; s < SETTLE; s++) begin
          e = '0; e.busy = 1; e.wori = 1; e.loc = 5'(NN - 1);
          m = full; m.addr = '0;
          exp_q.push_back(e); msk_q.push_back(m);
        end
      end
      for (int j = 0; j < len; j++) begin
        e = '0; e.busy = 1; e.ram_en = 1; e.mode = mode; e.mux = op;
        e.addr = 11'((src_base + j) % SPAN);
        e.ace  = (op == 2'b00);
        exp_q.push_back(e); msk_q.push_back(full);
      end
      for (int d = 0; d < DRAIN; d++) begin
        e = '0; e.busy = 1; e.mode = mode; e.mux = op;
        e.addr = 11'((src_base + len - 1) % SPAN);
        e.ace  = (op == 2'b00);
        exp_q.push_back(e); msk_q.push_back(full);
      end
    end
    e = '0; e.done = 1;
    exp_q.push_back(e); msk_q.push_back(full);
  endtask

  task automatic scramble_cfg();
    cfg_op       = 2'($urandom_range(0, 3));
    cfg_mode     = 3'($urandom_range(0, 7));
    cfg_w_base   = 11'($urandom_range(0, SPAN - 1));
    cfg_src_base = 11'($urandom_range(0, SPAN - 1));
    cfg_src_len  = 12'($urandom_range(0, SPAN));
  endtask

  task automatic drive_cfg(input logic [1:0] op, input logic [2:0] mode,
                           input int w_base, input int src_base, input int len);
    cfg_op       = op;
    cfg_mode     = mode;
    cfg_w_base   = 11'(w_base);
    cfg_src_base = 11'(src_base);
    cfg_src_len  = 12'(len);
  endtask

  // Runs one job end to end; with noise, start pulses and cfg junk arrive mid-job.
  task automatic run_job(input string name, input logic [1:0] op, input logic [2:0] mode,
                         input int w_base, input int src_base, input int len, input bit noise);
    logic [OUT_W-1:0] a, x, m;
    int n;
    build_model(op, mode, w_base, src_base, len);
    n = exp_q.size();
    @(posedge clk); #1;
    drive_cfg(op, mode, w_base, src_base, len);
    abort = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_cfg();
    for (int i = 0; i < n; i++) begin
      if (noise && i < n - 3) begin
        start = 1'($urandom_range(0, 1));
        scramble_cfg();
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      a = sample(); x = exp_q[i]; m = msk_q[i];
      check_cnt++;
      if ((a & m) !== (x & m))
        $display("[TB] FAIL %s cycle %0d: got %h expected %h (mask %h)", name, i + 1, a, x, m);
      else
        pass_cnt++;
    end
    start = 1'b0;
    @(posedge clk); #1;
    a = sample();
    check_cnt++;
    if (a !== '0) $display("[TB] FAIL %s_idle: got %h expected 0", name, a);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    logic [OUT_W-1:0] a;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    drive_cfg(2'b00, 3'b000, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    a = sample();
    check_cnt++;
    if (a !== '0) $display("[TB] FAIL reset_state: got %h expected 0", a);
    else pass_cnt++;
    #2 rst_n = 1'b1;

    // Async reset in the middle of a pool stream.
    @(posedge clk); #1;
    drive_cfg(2'b01, 3'b101, 0, 300, 30);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_cnt++;
    if (ctrl_ram_en !== 1'b1 || busy !== 1'b1)
      $display("[TB] FAIL pre_reset_run: got ram_en=%b busy=%b expected 1/1", ctrl_ram_en, busy);
    else pass_cnt++;
    #3 rst_n = 1'b0;
    #1;
    a = sample();
    check_cnt++;
    if (a !== '0) $display("[TB] FAIL reset_async: got %h expected 0", a);
    else pass_cnt++;
    @(posedge clk); #2 rst_n = 1'b1;
    run_job("after_reset", 2'b01, 3'b101, 0, 300, 30, 1'b0);
  endtask

  task automatic test_conv();
    run_job("conv", 2'b00, 3'b000, 1200, 0, 2048, 1'b0);
  endtask

  task automatic test_pool();
    run_job("pool", 2'b01, 3'b101, 0, 100, 16, 1'b0);
  endtask

  task automatic test_wrap();
    run_job("wrap", 2'b10, 3'b000, 0, 2040, 16, 1'b0);
  endtask

  task automatic test_abort();
    logic [OUT_W-1:0] a, x;
    int src;
    src = $urandom_range(0, SPAN - 1);
    build_model(2'b01, 3'b110, 0, src, 30);
    @(posedge clk); #1;
    drive_cfg(2'b01, 3'b110, 0, src, 30);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      a = sample(); x = exp_q[i];
      check_cnt++;
      if (a !== x) $display("[TB] FAIL abort_pre cycle %0d: got %h expected %h", i + 1, a, x);
      else pass_cnt++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = sample();
      check_cnt++;
      if (a !== '0) $display("[TB] FAIL abort_quiet cycle %0d: got %h expected 0", i, a);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    run_job("after_abort", 2'b01, 3'b110, 0, src, 30, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_job("busy_start_pool", 2'b01, 3'b101, 0, 500, 20, 1'b1);
    run_job("busy_start_conv", 2'b00, 3'b000, 2030, 7, 12, 1'b1);
  endtask

  task automatic test_len0();
    run_job("len0", 2'b00, 3'b000, 77, 9, 0, 1'b0);
    run_job("len0_relu", 2'b10, 3'b010, 0, 9, 0, 1'b0);
  endtask

  task automatic test_start_abort();
    logic [OUT_W-1:0] a;
    @(posedge clk); #1;
    drive_cfg(2'b01, 3'b101, 0, 40, 5);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = sample();
      check_cnt++;
      if (a !== '0) $display("[TB] FAIL start_abort cycle %0d: got %h expected 0", i, a);
      else pass_cnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      run_job("random", 2'($urandom_range(0, 2)), 3'($urandom_range(0, 7)),
              $urandom_range(0, SPAN - 1), $urandom_range(0, SPAN - 1),
              $urandom_range(0, 40), 1'b1);
    end
  endtask

  initial begin
    $display("[TB] dp_layer_sequencer bench start");
    test_reset();
    test_conv();
    test_pool();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_len0();
    test_start_abort();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/dp_layer_sequencer.md
Name: dp_layer_sequencer

Overview:
Control sequencer for the CNN datapath; replaces hand-driven bench stimulus with a start/busy/done engine.
For conv layers it preloads the NxN weight window from RAM, then streams the feature-map read addresses. For pool/relu layers it streams addresses only.
It drives every ctrl_* input of the datapath, and sits between the top-level layer scheduler and the datapath.

Parameters:
ADDR_WIDTH, 11, RAM address width
N, 5, kernel side; weight window holds N*N words
W_SETTLE_CYCLES, 2, idle cycles after weight preload, before streaming
DRAIN_CYCLES, 4, idle cycles after last read, with mode/mux held for pipeline drain

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
abort  in  1  cancel current job; priority over start
cfg_op  in  2  00 conv, 01 maxpool, 10 relu, 11 reserved (treated as relu)
cfg_mode  in  3  datapath mode (e.g. 000 conv, 101/110 pool)
cfg_w_base  in  ADDR_WIDTH  first weight address
cfg_src_base  in  ADDR_WIDTH  first feature-map address
cfg_src_len  in  ADDR_WIDTH+1  words to stream, 0..2^ADDR_WIDTH
busy  out  1  job in progress
done  out  1  one-cycle completion pulse
ctrl_ram_en  out  1  RAM read enable
ctrl_WorI  out  1  1 = weight load, 0 = inference
ctrl_mode  out  3  datapath mode
ctrl_mux_sel  out  2  output mux select (= op)
ctrl_read_addr  out  ADDR_WIDTH  RAM read address
ctrl_weight_location  out  $clog2(N*N)  weight register index
ctrl_addr_ctrl_en  out  1  line-buffer address controller enable

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. The async assert takes effect immediately, including mid-job.
- All outputs are registered. Cycle k means the k-th clock after the edge that sampled start.
- Config is captured on the accepted start edge. cfg_* changes during a job are ignored.
- IDLE: all outputs 0.
  - start & !abort & len==0 -> DONE.
  - start & !abort & op==conv -> LOAD_W.
  - start & !abort, other op -> RUN.
- LOAD_W (N*N cycles, k = 0..N*N-1):
  - ram_en=1, WorI=1.
  - read_addr = w_base+k (mod 2^ADDR_WIDTH); weight_location = k, aligned with read_addr.
  - Last k -> W_SETTLE.
- W_SETTLE (W_SETTLE_CYCLES cycles): ram_en=0, WorI=1, weight_location held at N*N-1. Then -> RUN.
- RUN (len cycles, j = 0..len-1):
  - ram_en=1, WorI=0, read_addr = src_base+j (mod 2^ADDR_WIDTH).
  - mode = cfg_mode, mux_sel = cfg_op, addr_ctrl_en = (op==conv).
  - weight_location = 0.
  - Last j -> DRAIN.
- DRAIN (DRAIN_CYCLES cycles): ram_en=0; mode, mux_sel, addr_ctrl_en held; read_addr held at last value. Then -> DONE.
- DONE (1 cycle): done=1, busy=0, other ctrl_* return to 0. Then -> IDLE.
- busy=1 in LOAD_W, W_SETTLE, RUN and DRAIN only.
- start while busy: ignored, no queueing.
- abort in any non-IDLE state: next cycle IDLE with all outputs 0, no done pulse.
- abort and start together in IDLE: start ignored.
- Counters: weight counter is $clog2(N*N) bits. Stream counter is ADDR_WIDTH+1 bits, so len = 2^ADDR_WIDTH completes without overflow. The address adder truncates to ADDR_WIDTH (wrap).
- Total conv job: N*N + W_SETTLE_CYCLES + len + DRAIN_CYCLES busy cycles, then done.

Decomposition:
- Package dp_ctrl_pkg:
  - op encodings OP_CONV / OP_POOL / OP_RELU;
  - state encodings IDLE, LOAD_W, W_SETTLE, RUN, DRAIN, DONE;
  - mux_sel values equal to op codes.
- Sub-module addr_seq_counter: base plus offset counter with load/enable/terminal-count outputs and ADDR_WIDTH wrap.
  - A single instance is reused for the weight and stream phases.
  - It is reloaded on each phase entry.

Test Plan:
1. rst_n low mid-RUN -> all outputs 0 immediately. Return to IDLE; the next start runs normally.
2. Conv job: w_base=1200, src_base=0, len=2048, mode=000.
   - Cycles 1..25: addr 1200..1224, loc 0..24, WorI=1.
   - Cycles 26..27: ram_en=0.
   - Cycles 28..2075: addr 0..2047, addr_ctrl_en=1, mux_sel=00.
   - Cycles 2076..2079: drain.
   - done=1 at cycle 2080.
3. Pool job: op=01, mode=101, src_base=100, len=16.
   - No WorI=1 cycle.
   - Cycles 1..16: addr 100..115, mux_sel=01, mode=101, addr_ctrl_en=0.
   - done at cycle 21.
4. Wrap: op=10, src_base=2040, len=16 -> addr 2040..2047 then 0..7; done at cycle 21.
5. abort at RUN j=10 -> next cycle ram_en=0, busy=0, no done pulse. A start 3 cycles later begins a fresh job at src_base.
6. Corner cases:
   - start pulse during busy: no effect on addresses or count.
   - len=0: done at cycle 1, ram_en never asserted.
   - start and abort together in IDLE: nothing happens.
